pll_dri_master: RTL
===================

// Module: pll_dri_master
// PURPOSE
// - Initiator on the PolarFire PLL Dynamic Reconfiguration Interface (DRI). Drives DRI_CLK, DRI_CTRL,
//   DRI_WDATA and DRI_ARST_N of the PLL0 primitive, and collects DRI_RDATA and DRI_INTERRUPT.
// - Sits beside PLL0 in the top level. Fabric logic issues PLL register reads/writes
//   (e.g. DIV0_VAL, FB_INT_VAL retune) over a valid/ready request port and gets one response per request.
// PARAMETERS
// - CLK_DIV   4    clock cycles per dri_clk half-period (>=1); dri_clk period = 2*CLK_DIV cycles
// - TIMEOUT   255  dri_clk rising edges to wait for ack before error (>=1)
// PORTS
// - clock          in   1   system clock; all logic on rising edge
// - reset_n        in   1   reset, asynchronous assert, active-low
// - req_valid      in   1   request valid
// - req_ready      out  1   request accepted when valid&ready
// - req_write      in   1   1=write, 0=read
// - req_addr       in   8   PLL DRI register address
// - req_wdata      in   32  write data (ignored for reads)
// - rsp_valid      out  1   one-cycle response pulse
// - rsp_rdata      out  32  read data (0 for writes/errors); held until next response
// - rsp_err        out  1   timeout flag, valid with rsp_valid
// - irq            out  1   dri_interrupt after 2-flop sync
// - dri_clk        out  1   divided DRI clock
// - dri_arst_n     out  1   DRI reset to PLL, active-low
// - dri_ctrl       out  11  {req, write, 1'b0, addr[7:0]}
// - dri_wdata      out  33  {1'b0, wdata[31:0]}
// - dri_rdata      in   33  {ack, rdata[31:0]}
// - dri_interrupt  in   1   PLL DRI interrupt
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE.
// - dri_arst_n = reset_n through 2-flop sync; rises on the 2nd clock edge after reset_n release.
// - dri_clk: counter 0..CLK_DIV-1, toggles dri_clk at CLK_DIV-1. Free-running while reset_n=1.
//   Rise/fall events = clock edges where dri_clk goes 0->1 / 1->0.
// - req_ready = (state==IDLE) & dri_arst_n. Combinational from registers only.
// - FSM:
//   - IDLE:   on valid&ready, capture write/addr/wdata -> SETUP.
//   - SETUP:  at next fall event drive dri_ctrl={1,write,0,addr}, dri_wdata={0,wdata} -> STROBE.
//   - STROBE: at next fall event clear dri_ctrl[10] (addr/write/wdata held) -> WAIT.
//     PLL sees req=1 on exactly one dri_clk rise.
//   - WAIT:   on each rise event sample dri_rdata. If [32]=1: rsp_rdata<=read?[31:0]:0 -> DONE.
//   - DONE:   rsp_valid=1 for one cycle; dri_ctrl, dri_wdata <= 0 -> IDLE.
// - req_valid during SETUP..DONE is not accepted. Earliest next acceptance: cycle after rsp_valid.
// - Ack already high at the first WAIT rise: accepted (completes on that rise).
// - reset_n low at any time: immediate return to reset values. In-flight transaction dropped;
//   no rsp_valid is emitted for it.
// CONFIGURATION
// - PLL_DRI_TIMEOUT_EN defined:
//   - WAIT counts rise events ($clog2(TIMEOUT+1) bits, cleared on entry).
//   - Count==TIMEOUT without ack -> DONE with rsp_err=1, rsp_rdata=0.
//   - Ack and timeout on the same rise: ack wins, rsp_err=0.
// - PLL_DRI_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely; rsp_err tied 0.
// TESTING
// - Reset: reset_n=0 -> all outputs 0. Release -> dri_arst_n=1 after 2 clocks, req_ready=1, dri_clk toggles every 4 clocks.
// - Write addr 0x2A data 0xDEADBEEF, model acks 2 rises after strobe -> dri_ctrl=0x62A on exactly one rise,
//   dri_wdata=0x0DEADBEEF, single rsp_valid, rsp_err=0, rsp_rdata=0.
// - Read addr 0x05, model returns 0x1_00000019 -> dri_ctrl=0x405 on one rise, rsp_rdata=0x00000019, rsp_err=0.
// - No ack, TIMEOUT=8, macro on -> rsp_valid with rsp_err=1 on 8th WAIT rise.
//   Macro off -> no rsp_valid after 1000 rises, req_ready stays 0.
// - reset_n pulsed low in WAIT -> dri_ctrl=0, no rsp_valid. After release a read to 0x05 completes normally.
// - req_valid held high for two writes -> second accepted the cycle after first rsp_valid; two rsp_valid pulses total.

Source files
------------

// File: rtl/pll_dri_master.sv
// pll_dri_master: initiator on the PolarFire PLL Dynamic Reconfiguration Interface.
// Turns fabric valid/ready register requests into DRI strobes on a divided dri_clk
// and returns one response per request.
// Build macro PLL_DRI_TIMEOUT_EN: when defined, WAIT gives up after TIMEOUT dri_clk
// rises without ack and answers with rsp_err=1; when undefined, WAIT holds forever.
`timescale 1ns/1ps
module pll_dri_master #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [7:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        irq,
   output logic        dri_clk,
   output logic        dri_arst_n,
   output logic [10:0] dri_ctrl,
   output logic [32:0] dri_wdata,
   input  logic [32:0] dri_rdata,
   input  logic        dri_interrupt
);

   localparam int unsigned        DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      WAIT   = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t            state;
   logic [DIV_W-1:0]  div_cnt;
   logic              div_tick_c;
   logic              rise_c;
   logic              fall_c;
   logic              arst_meta;
   logic              irq_meta;
   logic              cap_write;
   logic [7:0]        cap_addr;
   logic [31:0]       cap_wdata;

`ifdef PLL_DRI_TIMEOUT_EN
   localparam int unsigned       TO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);
   logic [TO_W-1:0]              wait_cnt;
   logic                         timeout_c;
   // Current rise is the TIMEOUT-th one seen in WAIT
   assign timeout_c = (wait_cnt == TO_LAST);
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
`endif

   // Rise/fall events are the clock edges on which dri_clk flips 0->1 / 1->0
   assign div_tick_c = (div_cnt == DIV_LAST);
   assign rise_c     = div_tick_c & ~dri_clk;
   assign fall_c     = div_tick_c & dri_clk;

   // New requests only while idle and the PLL side is out of reset
   assign req_ready  = (state == IDLE) & dri_arst_n;

   // Free-running dri_clk divider, half-period of CLK_DIV clocks
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         dri_clk <= 1'b0;
      end else if (div_tick_c) begin
         div_cnt <= '0;
         dri_clk <= ~dri_clk;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Reset release to the PLL and interrupt capture, both through 2-flop syncs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         arst_meta  <= 1'b0;
         dri_arst_n <= 1'b0;
         irq_meta   <= 1'b0;
         irq        <= 1'b0;
      end else begin
         arst_meta  <= 1'b1;
         dri_arst_n <= arst_meta;
         irq_meta   <= dri_interrupt;
         irq        <= irq_meta;
      end
   end

   // Transaction FSM: capture, strobe for exactly one rise, wait for ack, respond
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cap_write <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         dri_ctrl  <= '0;
         dri_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
`ifdef PLL_DRI_TIMEOUT_EN
         wait_cnt  <= '0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  cap_write <= req_write;
                  cap_addr  <= req_addr;
                  cap_wdata <= req_wdata;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               if (fall_c) begin
                  dri_ctrl  <= {1'b1, cap_write, 1'b0, cap_addr};
                  dri_wdata <= {1'b0, cap_wdata};
                  state     <= STROBE;
               end
            end
            STROBE: begin
               if (fall_c) begin
                  dri_ctrl[10] <= 1'b0;
`ifdef PLL_DRI_TIMEOUT_EN
                  wait_cnt     <= '0;
`endif
                  state        <= WAIT;
               end
            end
            WAIT: begin
               if (rise_c) begin
                  if (dri_rdata[32]) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= cap_write ? 32'd0 : dri_rdata[31:0];
                     rsp_err   <= 1'b0;
                     state     <= DONE;
                  end
`ifdef PLL_DRI_TIMEOUT_EN
                  else if (timeout_c) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= 32'd0;
                     rsp_err   <= 1'b1;
                     state     <= DONE;
                  end else begin
                     wait_cnt  <= wait_cnt + TO_W'(1);
                  end
`endif
               end
            end
            DONE: begin
               dri_ctrl  <= '0;
               dri_wdata <= '0;
               rsp_err   <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
